ping_pong_reader: RTL

Read-side sequencer that sits directly downstream of the ping-pong buffer. On a start command it selects a bank, issues a burst of sequential reads on the buffer's read port, absorbs the buffer's one-cycle read latency, and presents the words as a valid/ready stream with full backpressure support. It gives the downstream compute stage a lossless, one-word-per-cycle view of a completed bank.

---
 rtl/ping_pong_reader_pkg.sv | 16 +
 rtl/pp_skid_fifo.sv | 74 +++++++
 rtl/ping_pong_reader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ping_pong_reader_pkg.sv
// Shared types and constants for the ping-pong buffer read sequencer.
package ping_pong_reader_pkg;

   // Sequencer states: waiting for a command, issuing reads, waiting for
   // the last words to leave the skid FIFO.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Two entries cover the one-cycle read latency of the buffer plus one
   // word that may be sitting at the output while the consumer stalls.
   localparam int SKID_DEPTH = 2;

endpackage : ping_pong_reader_pkg

// File: rtl/pp_skid_fifo.sv
// Small skid FIFO that absorbs buffer read latency under backpressure.
// Head data is presented combinationally so a word can be consumed in
// the cycle after it was written.
module pp_skid_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2,
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count
);

   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic [WIDTH-1:0] entries [DEPTH];
   logic             pop_ok;
   logic             push_ok;

   // Pointer advance with wrap at the last entry.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Popping an empty FIFO is ignored; a push into a full FIFO only lands
   // when the head is leaving in the same cycle.
   assign pop_ok  = pop && (count_reg != '0);
   assign push_ok = push && ((count_reg != CW'(DEPTH)) || pop_ok);

   // One storage register per entry, written when the write pointer selects it.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [WIDTH-1:0] entry_reg;

         // Capture incoming word into this slot.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               entry_reg <= '0;
            end else if (push_ok && (wr_ptr_reg == PW'(gi))) begin
               entry_reg <= din;
            end
         end

         assign entries[gi] = entry_reg;
      end
   endgenerate

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         end
         if (pop_ok) begin
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         end
         count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
      end
   end

   assign head  = entries[rd_ptr_reg];
   assign count = count_reg;

endmodule : pp_skid_fifo

// File: rtl/ping_pong_reader.sv
// Read-side sequencer for the ping-pong buffer: latches a bank and length on
// start, streams the bank out through a credit-limited read pipeline and a
// skid FIFO, and pulses done once every word has been accepted downstream.
module ping_pong_reader
   import ping_pong_reader_pkg::*;
#(
   parameter int BIT_LENGTH = 64,
   parameter int DEPTH      = 16,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  bank_sel,
   input  logic [AW:0]           frame_len,
   output logic                  ping_pong,
   output logic                  enb,
   output logic [AW-1:0]         addrb,
   input  logic [BIT_LENGTH-1:0] doutb,
   output logic [BIT_LENGTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  busy,
   output logic                  done
);

   localparam int          CNT_W   = $clog2(SKID_DEPTH + 1);
   localparam int          OCC_W   = CNT_W + 1;
   localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

   state_t                 state_reg;
   state_t                 state_next;
   logic                   bank_reg;
   logic [AW:0]            len_reg;
   logic [AW:0]            addr_reg;
   logic [AW:0]            accepted_reg;
   logic                   pending_reg;
   logic                   busy_reg;

   logic [AW:0]            len_clamped;
   logic [AW:0]            addr_inc;
   logic                   start_accept;
   logic                   pop;
   logic                   credit_ok;
   logic [OCC_W-1:0]       occupancy;
   logic [CNT_W-1:0]       fifo_count;
   logic [BIT_LENGTH-1:0]  fifo_head;
   logic                   read_en;
   logic                   done_now;

   // Lengths beyond one bank are trimmed so the address never wraps.
   assign len_clamped = (frame_len > DEPTH_L) ? DEPTH_L : frame_len;
   assign addr_inc    = addr_reg + (AW + 1)'(1);

   assign pop = dout_valid && dout_ready;

   // Words in flight (stored plus the read returning now) minus the one
   // leaving this cycle must leave room for one more read.
   assign occupancy = OCC_W'(fifo_count) + OCC_W'(pending_reg);
   assign credit_ok = occupancy < (OCC_W'(SKID_DEPTH) + OCC_W'(pop));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state, read issue and completion decode.
   always_comb begin
      state_next   = state_reg;
      read_en      = 1'b0;
      done_now     = 1'b0;
      start_accept = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               start_accept = 1'b1;
               state_next   = (len_clamped == '0) ? DRAIN : READ;
            end
         end
         READ: begin
            if (addr_reg < len_reg) begin
               if (credit_ok) begin
                  read_en = 1'b1;
                  if (addr_inc >= len_reg) begin
                     state_next = DRAIN;
                  end
               end
            end else begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (!pending_reg && (fifo_count == '0) && (accepted_reg == len_reg)) begin
               done_now   = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Command latching, address and acceptance counters, read-latency tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_reg     <= 1'b0;
         len_reg      <= '0;
         addr_reg     <= '0;
         accepted_reg <= '0;
         pending_reg  <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         pending_reg <= read_en;
         if (start_accept) begin
            bank_reg     <= bank_sel;
            len_reg      <= len_clamped;
            addr_reg     <= '0;
            accepted_reg <= '0;
            busy_reg     <= 1'b1;
         end else begin
            if (read_en) begin
               addr_reg <= addr_inc;
            end
            if (pop) begin
               accepted_reg <= accepted_reg + (AW + 1)'(1);
            end
            if (done_now) begin
               busy_reg <= 1'b0;
            end
         end
      end
   end

   // Read data returns one cycle after enb and is always captured.
   pp_skid_fifo #(
      .WIDTH (BIT_LENGTH),
      .DEPTH (SKID_DEPTH)
   ) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (pending_reg),
      .din   (doutb),
      .pop   (pop),
      .head  (fifo_head),
      .count (fifo_count)
   );

   assign ping_pong  = bank_reg;
   assign enb        = read_en;
   assign addrb      = addr_reg[AW-1:0];
   assign dout       = fifo_head;
   assign dout_valid = (fifo_count != '0);
   assign busy       = busy_reg;
   assign done       = done_now;

endmodule : ping_pong_reader
